// File: rtl/alu_uart_interface.sv
// Operand sequencer between uart_rx, a registered ALU and uart_tx.
// Collects A, B, OP bytes, waits out the ALU latency and offers the result byte.
module alu_uart_interface #(
  parameter int N_BITS  = 6,
  parameter int N_DATA  = 8,
  parameter int ALU_LAT = 1,
  parameter int TIMEOUT = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_DATA-1:0] i_rx_data,
  input  logic              i_rx_valid,
  input  logic [N_BITS-1:0] i_res,
  output logic [N_BITS-1:0] o_A,
  output logic [N_BITS-1:0] o_B,
  output logic [N_BITS-1:0] o_OP,
  output logic [N_DATA-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_drop,
  output logic              o_timeout
);

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int EW = $clog2(ALU_LAT + 2);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [EW-1:0] EX_LAST = EW'(ALU_LAT);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND
  } state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] a_q, a_d;
  logic [N_BITS-1:0] b_q, b_d;
  logic [N_BITS-1:0] op_q, op_d;
  logic [N_DATA-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              drop_q, drop_d;
  logic              timeout_q, timeout_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [EW-1:0]     ecnt_q, ecnt_d;

  // Bytes wider than the ALU word are truncated; the high bits are deliberately unused.
  generate
    if (N_DATA > N_BITS) begin : g_rx_hi
      logic rx_hi_unused;
      assign rx_hi_unused = ^i_rx_data[N_DATA-1:N_BITS];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      drop_q     <= 1'b0;
      timeout_q  <= 1'b0;
      tcnt_q     <= '0;
      ecnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      drop_q     <= drop_d;
      timeout_q  <= timeout_d;
      tcnt_q     <= tcnt_d;
      ecnt_q     <= ecnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    drop_d     = 1'b0;
    timeout_d  = 1'b0;
    tcnt_d     = tcnt_q;
    ecnt_d     = ecnt_q;

    case (state_q)
      WAIT_A: begin
        if (i_rx_valid) begin
          a_d     = i_rx_data[N_BITS-1:0];
          tcnt_d  = '0;
          state_d = WAIT_B;
        end
      end

      WAIT_B, WAIT_OP: begin
        // An arriving byte always beats an expiring timeout.
        if (i_rx_valid) begin
          tcnt_d = '0;
          if (state_q == WAIT_B) begin
            b_d     = i_rx_data[N_BITS-1:0];
            state_d = WAIT_OP;
          end else begin
            op_d    = i_rx_data[N_BITS-1:0];
            ecnt_d  = '0;
            state_d = EXEC;
          end
        end else if (TIMEOUT != 0) begin
          if (tcnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            tcnt_d    = '0;
            state_d   = WAIT_A;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end

      EXEC: begin
        drop_d = i_rx_valid;
        if (ecnt_q == EX_LAST) begin
          tx_data_d  = N_DATA'(i_res);
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end else begin
          ecnt_d = ecnt_q + EW'(1);
        end
      end

      SEND: begin
        drop_d = i_rx_valid;
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = WAIT_A;
        end
      end

      default: state_d = WAIT_A;
    endcase
  end

  assign o_A        = a_q;
  assign o_B        = b_q;
  assign o_OP       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_drop     = drop_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: registered ALU stand-in, frame-level reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_alu_uart_interface;

  localparam int NB  = 6;
  localparam int ND  = 8;
  localparam int LAT = 1;
  localparam int TO  = 10;

  localparam int PH_COLLECT = 0;
  localparam int PH_EXEC    = 1;
  localparam int PH_SEND    = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [ND-1:0] rx_data;
  logic          rx_valid;
  logic [NB-1:0] alu_res = '0;
  logic [NB-1:0] o_A, o_B, o_OP;
  logic [ND-1:0] o_tx_data;
  logic          o_tx_valid;
  logic          tx_ready;
  logic          o_drop, o_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  int drop_count = 0;
  int to_count = 0;

  alu_uart_interface #(
    .N_BITS (NB),
    .N_DATA (ND),
    .ALU_LAT(LAT),
    .TIMEOUT(TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_rx_data (rx_data),
    .i_rx_valid(rx_valid),
    .i_res     (alu_res),
    .o_A       (o_A),
    .o_B       (o_B),
    .o_OP      (o_OP),
    .o_tx_data (o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(tx_ready),
    .o_drop    (o_drop),
    .o_timeout (o_timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [NB-1:0] alu_fn(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                           input logic [NB-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return '0;
    endcase
  endfunction

  // ALU stand-in: one-edge registered latency.
  always @(posedge clock) alu_res <= alu_fn(o_A, o_B, o_OP);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts bytes of the current frame and idle cycles, then
  // computes the result directly from the collected operands.
  logic [NB-1:0] m_a, m_b, m_op;
  logic [ND-1:0] m_tx_data;
  logic          m_tx_valid, m_drop, m_timeout;
  int            m_phase, m_got, m_idle, m_wait;

  always @(posedge clock) begin
    if (reset) begin
      m_a <= '0; m_b <= '0; m_op <= '0; m_tx_data <= '0;
      m_tx_valid <= 1'b0; m_drop <= 1'b0; m_timeout <= 1'b0;
      m_phase <= PH_COLLECT; m_got <= 0; m_idle <= 0; m_wait <= 0;
    end else begin
      m_drop    <= 1'b0;
      m_timeout <= 1'b0;
      case (m_phase)
        PH_COLLECT: begin
          if (rx_valid) begin
            m_idle <= 0;
            if (m_got == 0) m_a <= rx_data[NB-1:0];
            else if (m_got == 1) m_b <= rx_data[NB-1:0];
            else m_op <= rx_data[NB-1:0];
            if (m_got == 2) begin
              m_got   <= 0;
              m_phase <= PH_EXEC;
              m_wait  <= LAT + 1;
            end else begin
              m_got <= m_got + 1;
            end
          end else if (m_got != 0) begin
            if (m_idle + 1 == TO) begin
              m_timeout <= 1'b1;
              m_got     <= 0;
              m_idle    <= 0;
            end else begin
              m_idle <= m_idle + 1;
            end
          end
        end
        PH_EXEC: begin
          m_drop <= rx_valid;
          if (m_wait == 1) begin
            m_tx_data  <= ND'(alu_fn(m_a, m_b, m_op));
            m_tx_valid <= 1'b1;
            m_phase    <= PH_SEND;
          end else begin
            m_wait <= m_wait - 1;
          end
        end
        default: begin
          m_drop <= rx_valid;
          if (tx_ready) begin
            m_tx_valid <= 1'b0;
            m_phase    <= PH_COLLECT;
          end
        end
      endcase
    end
  end

  always @(negedge clock) begin
    chk("model_o_A", 16'(o_A), 16'(m_a));
    chk("model_o_B", 16'(o_B), 16'(m_b));
    chk("model_o_OP", 16'(o_OP), 16'(m_op));
    chk("model_o_tx_data", 16'(o_tx_data), 16'(m_tx_data));
    chk("model_o_tx_valid", 16'(o_tx_valid), 16'(m_tx_valid));
    chk("model_o_drop", 16'(o_drop), 16'(m_drop));
    chk("model_o_timeout", 16'(o_timeout), 16'(m_timeout));
    if (o_drop === 1'b1) drop_count++;
    if (o_timeout === 1'b1) to_count++;
  end

  always @(posedge clock) begin
    if (reset !== 1'b1 && o_tx_valid === 1'b1 && tx_ready === 1'b1) hs_count++;
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
  endtask

  // Waits for the result after the OP byte; latency must be ALU_LAT+1 edges.
  task automatic wait_result(input logic [7:0] exp, input string name);
    int n;
    int hs0;
    n = 0;
    while (o_tx_valid !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    chk({name, "_latency"}, 16'(n), 16'd2);
    chk({name, "_data"}, 16'(o_tx_data), 16'(exp));
    if (tx_ready === 1'b1) begin
      hs0 = hs_count;
      cycle();
      chk({name, "_valid_drop"}, 16'(o_tx_valid), 16'd0);
      chk({name, "_one_handshake"}, 16'(hs_count - hs0), 16'd1);
    end
    $display("frame %s: tx_data=0x%02h latency=%0d", name, o_tx_data, n);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp, input string name);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    wait_result(exp, name);
  endtask

  task automatic check_cleared(input string name);
    chk({name, "_A"}, 16'(o_A), 16'd0);
    chk({name, "_B"}, 16'(o_B), 16'd0);
    chk({name, "_OP"}, 16'(o_OP), 16'd0);
    chk({name, "_tx_data"}, 16'(o_tx_data), 16'd0);
    chk({name, "_tx_valid"}, 16'(o_tx_valid), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hs0, d0, t0, at_idx, stable_bad;
    logic [7:0] held, a_before;

    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
    repeat (3) cycle();
    check_cleared("reset");
    chk("reset_drop", 16'(o_drop), 16'd0);
    chk("reset_timeout", 16'(o_timeout), 16'd0);
    reset = 1'b0;
    cycle();

    // Basic ADD frame
    run_frame(8'h05, 8'h03, 8'h20, 8'h08, "add");
    chk("add_A", 16'(o_A), 16'h05);
    chk("add_B", 16'(o_B), 16'h03);
    chk("add_OP", 16'(o_OP), 16'h20);

    // SUB wraps in 6 bits, OR with truncated A
    run_frame(8'h03, 8'h05, 8'h22, 8'h3E, "sub");
    run_frame(8'hFF, 8'h00, 8'h25, 8'h3F, "or");
    chk("or_A_trunc", 16'(o_A), 16'h3F);

    // Back-pressure with a byte dropped during SEND
    tx_ready = 1'b0;
    send_byte(8'h09); send_byte(8'h04); send_byte(8'h20);
    n = 0;
    while (o_tx_valid !== 1'b1 && n < 20) begin cycle(); n++; end
    chk("bp_valid", 16'(o_tx_valid), 16'd1);
    held = o_tx_data; a_before = 8'(o_A); d0 = drop_count; hs0 = hs_count; stable_bad = 0;
    for (int i = 0; i < 20; i++) begin
      rx_valid = (i == 5);
      rx_data  = 8'h11;
      cycle();
      if (o_tx_valid !== 1'b1 || o_tx_data !== held) stable_bad++;
    end
    rx_valid = 1'b0;
    chk("bp_stable", 16'(stable_bad), 16'd0);
    chk("bp_data", 16'(held), 16'h0D);
    chk("bp_drop_once", 16'(drop_count - d0), 16'd1);
    chk("bp_A_kept", 16'(o_A), 16'(a_before));
    chk("bp_no_hs_yet", 16'(hs_count - hs0), 16'd0);
    tx_ready = 1'b1;
    cycle();
    chk("bp_valid_low", 16'(o_tx_valid), 16'd0);
    cycle();
    chk("bp_one_hs", 16'(hs_count - hs0), 16'd1);
    $display("backpressure: held=0x%02h drops=%0d", held, drop_count - d0);

    // Timeout after a lone A byte
    t0 = to_count; at_idx = -1;
    send_byte(8'h07);
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (o_timeout === 1'b1 && at_idx < 0) at_idx = i;
    end
    chk("to_index", 16'(at_idx), 16'd10);
    chk("to_once", 16'(to_count - t0), 16'd1);
    chk("to_A_kept", 16'(o_A), 16'h07);
    run_frame(8'h01, 8'h02, 8'h20, 8'h03, "after_timeout");

    // Byte lands on the cycle the timeout would expire
    t0 = to_count;
    send_byte(8'h07);
    repeat (9) cycle();
    send_byte(8'h01);
    send_byte(8'h20);
    wait_result(8'h08, "edge_byte");
    chk("edge_no_timeout", 16'(to_count - t0), 16'd0);

    // Reset during EXEC
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
    hs0 = hs_count;
    reset = 1'b1; cycle(); reset = 1'b0;
    check_cleared("rst_exec");
    repeat (3) cycle();
    chk("rst_exec_no_hs", 16'(hs_count - hs0), 16'd0);
    chk("rst_exec_idle", 16'(o_tx_valid), 16'd0);
    run_frame(8'h02, 8'h02, 8'h24, 8'h02, "and_after_exec_rst");

    // Reset during SEND
    tx_ready = 1'b0;
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
    n = 0;
    while (o_tx_valid !== 1'b1 && n < 20) begin cycle(); n++; end
    chk("rst_send_valid", 16'(o_tx_valid), 16'd1);
    hs0 = hs_count;
    reset = 1'b1; cycle(); reset = 1'b0;
    check_cleared("rst_send");
    tx_ready = 1'b1;
    repeat (3) cycle();
    chk("rst_send_no_hs", 16'(hs_count - hs0), 16'd0);
    run_frame(8'h02, 8'h02, 8'h24, 8'h02, "and_after_send_rst");

    repeat (2) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
- Operand sequencer on the producer side of the ALU.
- Collects three bytes (A, B, OP) from the UART receiver's byte/valid interface and drives the held operand/opcode inputs of the registered ALU.
- Waits the ALU latency, captures the result, and offers it as one byte to the UART transmitter over a valid/ready handshake.
- Sits between uart_rx, the ALU and uart_tx in the board top.

Parameters:
- N_BITS, 6, ALU operand/opcode/result width.
- N_DATA, 8, UART byte width; must be >= N_BITS.
- ALU_LAT, 1, ALU clock-edge latency from operand change to valid result.
- TIMEOUT, 50000, idle cycles allowed in WAIT_B/WAIT_OP before the frame is abandoned; 0 disables the timeout.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous active-high reset.
- i_rx_data  in  N_DATA  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in that cycle.
- i_res  in  N_BITS  ALU result.
- o_A  out  N_BITS  operand A to ALU, registered, held.
- o_B  out  N_BITS  operand B to ALU, registered, held.
- o_OP  out  N_BITS  opcode to ALU, registered, held.
- o_tx_data  out  N_DATA  result byte to transmitter.
- o_tx_valid  out  1  result byte available.
- i_tx_ready  in  1  transmitter accepts the byte in a cycle where valid&ready.
- o_drop  out  1  one-cycle pulse: a byte arrived while busy and was discarded.
- o_timeout  out  1  one-cycle pulse: partial frame abandoned.

Behaviour:
- Reset:
  - Synchronous, active-high, on posedge clock; wins over every other event, including mid-frame, EXEC or SEND.
  - State goes to WAIT_A.
  - o_A, o_B, o_OP, o_tx_data = 0.
  - o_tx_valid, o_drop, o_timeout = 0.
  - Timeout and exec counters = 0.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
- WAIT_A:
  - On i_rx_valid: o_A <= i_rx_data[N_BITS-1:0] (upper bits discarded); go to WAIT_B.
  - Never times out.
- WAIT_B:
  - On i_rx_valid: o_B <= low N_BITS; go to WAIT_OP.
- WAIT_OP:
  - On i_rx_valid: o_OP <= low N_BITS; exec counter <= 0; go to EXEC.
- Timeout (WAIT_B and WAIT_OP only):
  - Counter clears on entry and on every accepted byte; increments each cycle without i_rx_valid.
  - When it reaches TIMEOUT: pulse o_timeout, go to WAIT_A.
  - o_A/o_B/o_OP keep their last values.
  - If i_rx_valid arrives in the same cycle the counter reaches TIMEOUT, the byte wins: it is accepted and no timeout occurs.
- EXEC:
  - Lasts exactly ALU_LAT+1 cycles; operands are not modified.
  - On its last cycle: o_tx_data <= {zero-extend, i_res}, o_tx_valid <= 1, go to SEND.
  - With ALU_LAT=1: OP accepted at edge k; result captured at edge k+2; o_tx_valid high after edge k+2.
- SEND:
  - o_tx_valid and o_tx_data stay stable until a cycle with i_tx_ready=1.
  - At that edge: o_tx_valid <= 0, go to WAIT_A.
  - i_tx_ready is ignored when o_tx_valid=0.
- Busy drop:
  - i_rx_valid in EXEC or SEND discards the byte and pulses o_drop the next cycle.
  - State, operands and result are unaffected. No buffering.
- Unknown opcodes are forwarded unchanged; the returned result is whatever the ALU holds.
- Arithmetic: no width extension here; the result is exactly the ALU's N_BITS value, zero-extended to N_DATA.

Test Plan:
- reset; send 0x05, 0x03, 0x20 (ADD), i_tx_ready=1 -> o_A=5, o_B=3, o_OP=0x20; o_tx_data=0x08 with o_tx_valid high exactly 2 cycles after the OP strobe for one cycle; state returns to WAIT_A.
- send 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0x3E (6-bit wrap). Then send 0xFF, 0x00, 0x25 (OR) -> o_A=0x3F, o_tx_data=0x3F.
- full frame with i_tx_ready=0 for 20 cycles, plus a byte 0x11 injected during SEND -> o_tx_valid and o_tx_data held constant for all 20 cycles; o_drop pulses once; o_A unchanged; when ready rises, exactly one handshake occurs.
- TIMEOUT=10; send 0x07 then idle 10 cycles -> o_timeout pulses once at the 10th idle cycle; next bytes 0x01, 0x02, 0x20 yield o_tx_data=0x03 (0x07 not reused as A).
- byte arriving in the same cycle the timeout counter hits TIMEOUT -> accepted; no o_timeout pulse.
- reset asserted for 1 cycle during EXEC and, separately, during SEND -> all outputs 0 next cycle; no tx handshake; a following frame 0x02, 0x02, 0x24 (AND) returns 0x02.
